display_mux: RTL and testbench

Two-digit time-multiplexed display driver that sits directly upstream of the seven-segment decoder. It captures hex key codes into a two-digit history (newest on the right) and alternates the shared 4-bit digit nibble between the two digits. It drives the two active-low anode enables and inserts a blanking interval at each switch so neither digit shows a ghost image.

---
 rtl/display_pkg.sv | 15 +
 rtl/display_phase_timer.sv | 40 ++++
 rtl/display_mux.sv | 107 ++++++++++
 tb/tb_display_mux.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit multiplexed display driver.
package display_pkg;

    typedef enum logic [1:0] {
        SHOW_R   = 2'd0,
        BLANK_RL = 2'd1,
        SHOW_L   = 2'd2,
        BLANK_LR = 2'd3
    } disp_state_t;

    localparam logic [1:0] AN_OFF   = 2'b11;
    localparam logic [1:0] AN_RIGHT = 2'b10;
    localparam logic [1:0] AN_LEFT  = 2'b01;

endpackage

// File: rtl/display_phase_timer.sv
// Phase timer: counts 0..N-1 in the current refresh state and flags the last cycle.
module display_phase_timer
    import display_pkg::*;
#(
    parameter int SHOW_CYCLES  = 12000,
    parameter int BLANK_CYCLES = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  disp_state_t state,
    output logic        phase_done
);

    localparam int MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] last_cnt;

    always_comb begin
        if (state == SHOW_R || state == SHOW_L) begin
            last_cnt = CW'(SHOW_CYCLES - 1);
        end else begin
            last_cnt = CW'(BLANK_CYCLES - 1);
        end
        phase_done = (cnt_q == last_cnt);
        // restart at zero together with the state change, never wrap mid-state
        cnt_d = phase_done ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_mux.sv
// Two-digit time-multiplexed display driver: key history, refresh FSM with
// blanking between digits, and registered select/anode outputs.
module display_mux
    import display_pkg::*;
#(
    parameter int SHOW_CYCLES  = 12000,
    parameter int BLANK_CYCLES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       clear,
    output logic [3:0] select,
    output logic [1:0] an
);

    disp_state_t state_q, state_d;
    logic [3:0]  dig_r_q, dig_r_d, dig_l_q, dig_l_d;
    logic        val_r_q, val_r_d, val_l_q, val_l_d;
    logic [3:0]  select_q, select_d;
    logic [1:0]  an_q, an_d;
    logic        phase_done;

    display_phase_timer #(
        .SHOW_CYCLES (SHOW_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .state     (state_q),
        .phase_done(phase_done)
    );

    always_comb begin
        state_d = state_q;
        if (phase_done) begin
            case (state_q)
                SHOW_R:   state_d = BLANK_RL;
                BLANK_RL: state_d = SHOW_L;
                SHOW_L:   state_d = BLANK_LR;
                BLANK_LR: state_d = SHOW_R;
                default:  state_d = SHOW_R;
            endcase
        end

        dig_r_d = dig_r_q;
        dig_l_d = dig_l_q;
        val_r_d = val_r_q;
        val_l_d = val_l_q;
        if (clear) begin
            dig_r_d = 4'h0;
            dig_l_d = 4'h0;
            val_r_d = 1'b0;
            val_l_d = 1'b0;
        end else if (key_valid) begin
            dig_l_d = dig_r_q;
            val_l_d = val_r_q;
            dig_r_d = key_code;
            val_r_d = 1'b1;
        end

        // blank states pre-load the next digit so the decoder settles while dark
        case (state_q)
            SHOW_R: begin
                select_d = dig_r_q;
                an_d     = val_r_q ? AN_RIGHT : AN_OFF;
            end
            BLANK_RL: begin
                select_d = dig_l_q;
                an_d     = AN_OFF;
            end
            SHOW_L: begin
                select_d = dig_l_q;
                an_d     = val_l_q ? AN_LEFT : AN_OFF;
            end
            default: begin
                select_d = dig_r_q;
                an_d     = AN_OFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SHOW_R;
            dig_r_q  <= 4'h0;
            dig_l_q  <= 4'h0;
            val_r_q  <= 1'b0;
            val_l_q  <= 1'b0;
            select_q <= 4'h0;
            an_q     <= AN_OFF;
        end else begin
            state_q  <= state_d;
            dig_r_q  <= dig_r_d;
            dig_l_q  <= dig_l_d;
            val_r_q  <= val_r_d;
            val_l_q  <= val_l_d;
            select_q <= select_d;
            an_q     <= an_d;
        end
    end

    assign select = select_q;
    assign an     = an_q;

endmodule

// File: tb/tb_display_mux.sv
// Randomized and directed bench for display_mux against a cycle-count reference model.
module tb_display_mux;

    localparam int S      = 4;
    localparam int B      = 2;
    localparam int PERIOD = 2 * (S + B);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       clear = 1'b0;
    logic [3:0] select;
    logic [1:0] an;

    int total = 0;
    int bad   = 0;

    // reference model: edges since reset and the two-digit history as a tiny array
    int         n_edges = 0;
    logic [3:0] m_dig [2];
    logic       m_val [2];
    logic [3:0] exp_sel;
    logic [1:0] exp_an;
    int         lit_r_cnt;

    display_mux #(
        .SHOW_CYCLES (S),
        .BLANK_CYCLES(B)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_valid(key_valid),
        .key_code (key_code),
        .clear    (clear),
        .select   (select),
        .an       (an)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int phase_pos();
        return n_edges % PERIOD;
    endfunction

    task automatic tick(input logic kv, input logic [3:0] kc, input logic clr, input logic rst);
        int p;
        key_valid = kv;
        key_code  = kc;
        clear     = clr;
        reset     = rst;
        @(posedge clk);
        if (rst) begin
            n_edges  = 0;
            m_dig[0] = 4'h0; m_dig[1] = 4'h0;
            m_val[0] = 1'b0; m_val[1] = 1'b0;
            exp_sel  = 4'h0;
            exp_an   = 2'b11;
        end else begin
            p = phase_pos();
            if (p < S) begin
                exp_sel = m_dig[0];
                exp_an  = m_val[0] ? 2'b10 : 2'b11;
            end else if (p < S + B) begin
                exp_sel = m_dig[1];
                exp_an  = 2'b11;
            end else if (p < 2 * S + B) begin
                exp_sel = m_dig[1];
                exp_an  = m_val[1] ? 2'b01 : 2'b11;
            end else begin
                exp_sel = m_dig[0];
                exp_an  = 2'b11;
            end
            if (clr) begin
                m_dig[0] = 4'h0; m_dig[1] = 4'h0;
                m_val[0] = 1'b0; m_val[1] = 1'b0;
            end else if (kv) begin
                m_dig[1] = m_dig[0]; m_val[1] = m_val[0];
                m_dig[0] = kc;       m_val[0] = 1'b1;
            end
            n_edges++;
        end
        #1;
        chk_eq("select", {4'h0, select}, {4'h0, exp_sel});
        chk_eq("an", {6'h0, an}, {6'h0, exp_an});
        chk_eq("an_not_both", {7'h0, an == 2'b00}, 8'h0);
        if (an == 2'b10) lit_r_cnt++;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick(1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        int in_l;

        // reset, then a blank display for two full periods
        tick(1'b0, 4'h0, 1'b0, 1'b1);
        tick(1'b0, 4'h0, 1'b0, 1'b1);
        chk_eq("reset_select", {4'h0, select}, 8'h00);
        chk_eq("reset_an", {6'h0, an}, 8'h03);
        lit_r_cnt = 0;
        idle(24);
        chk_eq("idle_no_lit", 8'(lit_r_cnt), 8'd0);

        // single key A lights only the right digit
        tick(1'b0, 4'h0, 1'b0, 1'b1);
        tick(1'b1, 4'hA, 1'b0, 1'b0);
        lit_r_cnt = 0;
        idle(PERIOD);
        chk_eq("key_a_right_lit", 8'(lit_r_cnt), 8'(S));

        // back-to-back keys 3 then 7
        tick(1'b1, 4'h3, 1'b0, 1'b0);
        tick(1'b1, 4'h7, 1'b0, 1'b0);
        idle(PERIOD);

        // three keys: the oldest falls off, then random traffic
        tick(1'b1, 4'h1, 1'b0, 1'b0);
        tick(1'b1, 4'h2, 1'b0, 1'b0);
        tick(1'b1, 4'hF, 1'b0, 1'b0);
        idle(PERIOD);
        for (int i = 0; i < 100; i++) begin
            tick(1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 15) == 0), 1'b0);
        end

        // clear wins over a simultaneous key
        tick(1'b1, 4'h8, 1'b0, 1'b0);
        tick(1'b1, 4'h9, 1'b0, 1'b0);
        tick(1'b1, 4'h5, 1'b1, 1'b0);
        lit_r_cnt = 0;
        idle(PERIOD);
        chk_eq("clear_no_lit", 8'(lit_r_cnt), 8'd0);

        // reset in the middle of SHOW_L
        tick(1'b1, 4'h6, 1'b0, 1'b0);
        tick(1'b1, 4'hC, 1'b0, 1'b0);
        for (int i = 0; i < 2 * PERIOD; i++) begin
            if (phase_pos() >= S + B + 1 && phase_pos() < 2 * S + B) break;
            idle(1);
        end
        in_l = (phase_pos() >= S + B && phase_pos() < 2 * S + B) ? 1 : 0;
        chk_eq("reached_show_l", 8'(in_l), 8'd1);
        tick(1'b0, 4'h0, 1'b0, 1'b1);
        tick(1'b1, 4'hD, 1'b0, 1'b0);
        chk_eq("post_reset_an", {6'h0, an}, 8'h03);
        chk_eq("post_reset_select", {4'h0, select}, 8'h00);
        lit_r_cnt = 0;
        idle(PERIOD);
        chk_eq("post_reset_show_r_len", 8'(lit_r_cnt), 8'(S));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
